// File: rtl/mult_pkg.sv
// Shared constants and helpers for the fixed-point multiplier.
package mult_pkg;

  localparam int MULT_WIDTH_DEF = 32;
  localparam int MULT_FRAC_DEF  = 0;
  localparam int MULT_LATENCY   = 2;
  localparam int MULT_MAX_W     = 64;

  // Low w bits hold 0111...1
  function automatic logic [MULT_MAX_W-1:0] mult_max_pos(input int w);
    return (MULT_MAX_W'(1) << (w - 1)) - MULT_MAX_W'(1);
  endfunction

  // Low w bits hold 1000...0
  function automatic logic [MULT_MAX_W-1:0] mult_max_neg(input int w);
    return MULT_MAX_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/fixed_point_multiplier_sat_clamp.sv
// Narrows the rescaled 2*WIDTH product to WIDTH bits and flags overflow.
// MULT_SATURATE_EN selects clamping on overflow; otherwise the value wraps.
module sat_clamp
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEF
) (
  input  logic [2*WIDTH-1:0] s_i,
  output logic [WIDTH-1:0]   result_o,
  output logic               overflow_o
);

  // In range only when every bit from WIDTH-1 upward copies the sign
  assign overflow_o = !((&s_i[2*WIDTH-1:WIDTH-1]) || !(|s_i[2*WIDTH-1:WIDTH-1]));

`ifdef MULT_SATURATE_EN
  localparam logic [MULT_MAX_W-1:0] MAXP = mult_max_pos(WIDTH);
  localparam logic [MULT_MAX_W-1:0] MAXN = mult_max_neg(WIDTH);

  always_comb begin
    result_o = s_i[WIDTH-1:0];
    if (overflow_o) result_o = s_i[2*WIDTH-1] ? MAXN[WIDTH-1:0] : MAXP[WIDTH-1:0];
  end
`else
  assign result_o = s_i[WIDTH-1:0];
`endif

endmodule

// File: rtl/fixed_point_multiplier.sv
// Two-stage signed fixed-point multiplier: operand register, then rescale/clamp register.
// Build option MULT_SATURATE_EN (in sat_clamp) clamps overflowed results.
module fixed_point_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH     = MULT_WIDTH_DEF,
  parameter int FRAC_BITS = MULT_FRAC_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             overflow_o
);

  logic [MULT_LATENCY:1]       vld_pipe_q;
  logic [WIDTH-1:0]            x_q, y_q;
  logic [WIDTH-1:0]            res_q, res_d;
  logic                        ovf_q, ovf_d;
  logic signed [2*WIDTH-1:0]   xe, ye, prod, scaled;

  assign xe     = {{WIDTH{x_q[WIDTH-1]}}, x_q};
  assign ye     = {{WIDTH{y_q[WIDTH-1]}}, y_q};
  assign prod   = xe * ye;
  assign scaled = prod >>> FRAC_BITS;

  sat_clamp #(.WIDTH(WIDTH)) u_clamp (
    .s_i       (scaled),
    .result_o  (res_d),
    .overflow_o(ovf_d)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      res_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[MULT_LATENCY-1:1], in_valid_i};
      if (in_valid_i) begin
        x_q <= x_i;
        y_q <= y_i;
      end
      // Outputs only move when a real pair reaches them, so they hold otherwise
      if (vld_pipe_q[1]) begin
        res_q <= res_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid_o = vld_pipe_q[MULT_LATENCY];
  assign result_o    = res_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Bench for fixed_point_multiplier: an integer DUT and a Q16.16 DUT share stimulus,
// checked by directed vectors plus a scoreboard built on 64-bit arithmetic.
module tb_fixed_point_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] x = '0, y = '0;
  logic        ov0, of0, ov16, of16;
  logic [31:0] res0, res16;

  int tests = 0, fails = 0, ncyc = 0, emitted = 0;

  always #5 clk = ~clk;

  fixed_point_multiplier #(.WIDTH(32), .FRAC_BITS(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .x_i(x), .y_i(y),
    .out_valid_o(ov0), .result_o(res0), .overflow_o(of0));

  fixed_point_multiplier #(.WIDTH(32), .FRAC_BITS(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .x_i(x), .y_i(y),
    .out_valid_o(ov16), .result_o(res16), .overflow_o(of16));

  // {overflow, result} from exact 64-bit arithmetic
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input int frac);
    logic signed [63:0] p, s;
    logic               ov;
    logic [31:0]        r;
    p  = 64'($signed(a)) * 64'($signed(b));
    s  = p >>> frac;
    ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    r  = s[31:0];
`ifdef MULT_SATURATE_EN
    if (ov) r = (s < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {ov, r};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  typedef struct {
    logic [32:0] e0;
    logic [32:0] e16;
    int          stamp;
  } exp_t;
  exp_t        q[$];
  logic [32:0] hold0 = '0, hold16 = '0;

  // Scoreboard: a pair seen at negedge k must show up at negedge k+2
  always @(negedge clk) begin
    exp_t e;
    bit   ev;
    ncyc++;
    ev = (q.size() != 0) && (q[0].stamp + 2 == ncyc);
    chk("out_valid0", 64'(ov0), 64'(ev));
    chk("out_valid16", 64'(ov16), 64'(ev));
    if (ev) begin
      e = q.pop_front();
      hold0  = e.e0;
      hold16 = e.e16;
      emitted++;
    end
    chk("result0", 64'(res0), 64'(hold0[31:0]));
    chk("overflow0", 64'(of0), 64'(hold0[32]));
    chk("result16", 64'(res16), 64'(hold16[31:0]));
    chk("overflow16", 64'(of16), 64'(hold16[32]));
    if (rst) begin
      q.delete();
      hold0  = '0;
      hold16 = '0;
    end else if (in_valid) begin
      e.e0    = model(x, y, 0);
      e.e16   = model(x, y, 16);
      e.stamp = ncyc;
      q.push_back(e);
    end
  end

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    bit          f16;
    logic [31:0] res;
    bit          ovf;
  } vec_t;
  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ovf_res, big_res;
    int          base;
`ifdef MULT_SATURATE_EN
    ovf_res = 32'h8000_0000;
    big_res = 32'h7FFF_FFFF;
`else
    ovf_res = 32'hBCC1_B2F9;
    big_res = 32'h0000_0000;
`endif
    tbl.push_back('{"small",     32'h0000_0004, 32'h0000_0002, 1'b0, 32'h0000_0008, 1'b0});
    tbl.push_back('{"square",    32'h0000_0435, 32'h0000_0435, 1'b0, 32'h0011_B2F9, 1'b0});
    tbl.push_back('{"neg_a",     32'hFFFF_FF18, 32'h0000_0435, 1'b0, 32'hFFFC_2FF8, 1'b0});
    tbl.push_back('{"neg_b",     32'hFFFF_FFFE, 32'h0000_0002, 1'b0, 32'hFFFF_FFFC, 1'b0});
    tbl.push_back('{"ovf",       32'h7FF0_0435, 32'h8000_0435, 1'b0, ovf_res,       1'b1});
    tbl.push_back('{"minmin",    32'h8000_0000, 32'h8000_0000, 1'b0, big_res,       1'b1});
    tbl.push_back('{"m1m1",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 1'b0});
    tbl.push_back('{"zero",      32'h1234_5678, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0});
    tbl.push_back('{"q16_mul",   32'h0001_8000, 32'h0002_0000, 1'b1, 32'h0003_0000, 1'b0});
    tbl.push_back('{"q16_trunc", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0});

    // Reset state
    @(negedge clk);
    chk("rst_valid", 64'({ov0, ov16}), 64'd0);
    chk("rst_result", 64'({res0, res16}), 64'd0);
    chk("rst_ovf", 64'({of0, of16}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Directed vectors, one at a time
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      x = tbl[i].a; y = tbl[i].b; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      if (tbl[i].f16) begin
        chk({tbl[i].name, "_valid"}, 64'(ov16), 64'd1);
        chk({tbl[i].name, "_res"}, 64'(res16), 64'(tbl[i].res));
        chk({tbl[i].name, "_ovf"}, 64'(of16), 64'(tbl[i].ovf));
      end else begin
        chk({tbl[i].name, "_valid"}, 64'(ov0), 64'd1);
        chk({tbl[i].name, "_res"}, 64'(res0), 64'(tbl[i].res));
        chk({tbl[i].name, "_ovf"}, 64'(of0), 64'(tbl[i].ovf));
      end
    end

    // Random stream with occasional resets
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 39) == 0);
      for (int k = 0; k < 2; k++) begin
        logic [31:0] v;
        case ($urandom_range(0, 7))
          0: v = 32'h0;
          1: v = 32'hFFFF_FFFF;
          2: v = 32'h8000_0000;
          3: v = 32'h7FFF_FFFF;
          4: v = 32'($signed(16'($urandom)));
          default: v = $urandom;
        endcase
        if (k == 0) x = v; else y = v;
      end
    end
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
    repeat (4) @(posedge clk);

    // Five back-to-back pairs; reset lands with the fifth, killing pairs 4 and 5
    #1 base = emitted;
    for (int n = 1; n <= 5; n++) begin
      x = 32'(n * 3); y = 32'(n + 100); in_valid = 1'b1;
      if (n == 5) rst = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 64'({ov0, ov16}), 64'd0);
    chk("post_rst_result", 64'({res0, res16}), 64'd0);
    chk("post_rst_ovf", 64'({of0, of16}), 64'd0);
    repeat (6) @(negedge clk);
    chk("stream_emitted", 64'(emitted - base), 64'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fixed_point_multiplier.md
# fixed_point_multiplier

Pipelined signed two's-complement multiplier for the handwritten-digit neural network datapath. It sits between the weight/activation fetch logic and the accumulator. Each cycle it takes two WIDTH-bit fixed-point operands and produces their WIDTH-bit product, rescaled by FRAC_BITS. It includes overflow detection and optional saturation.

## Interface
- WIDTH, 32: operand and result width in bits, signed two's complement.
- FRAC_BITS, 0: fractional bits in the operands and the result. 0 means plain integer; 16 means Q16.16. Legal range is 0..WIDTH-1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  x and y are valid this cycle.
- x  input  WIDTH  signed operand A.
- y  input  WIDTH  signed operand B.
- out_valid  output  1  result and overflow are valid.
- result  output  WIDTH  signed product, rescaled.
- overflow  output  1  the rescaled product did not fit in WIDTH signed bits.

## Operation
- Full product: p = signed(x) * signed(y), 2*WIDTH bits wide, exact.
- Rescale: s = p >>> FRAC_BITS, an arithmetic shift. This truncates toward minus infinity; there is no rounding.
- Range check: overflow = 1 when s > 2^(WIDTH-1)-1 or s < -2^(WIDTH-1).
- Result when in range: result = s[WIDTH-1:0].
- Result when out of range: set by the configuration macro (see Configuration).
- There is no backpressure. The block accepts one operand pair per cycle and every accepted pair produces exactly one output.
- Outputs hold their last value while out_valid = 0.
- Edge cases:
  - 0x80000000 * 0x80000000 (WIDTH=32, FRAC_BITS=0) is +2^62 and overflows.
  - -1 * -1 gives 1 with no overflow.
  - Any operand multiplied by 0 gives 0.

## Timing
- Latency is 2 cycles.
- Stage 1 registers x, y and in_valid.
- Stage 2 registers result, overflow and out_valid.
- A pair presented with in_valid at edge N appears with out_valid = 1 after edge N+2.
- Throughput is 1 pair per cycle. Back-to-back pairs come out back-to-back, in order.
- Reset values: out_valid = 0, result = 0, overflow = 0, and all pipeline registers = 0.
- Reset asserted mid-flight discards every in-flight pair. out_valid stays 0 until 2 cycles after the first in_valid sampled with rst = 0.
- in_valid sampled in the same cycle as rst = 1 is ignored.

## Configuration
- MULT_SATURATE_EN defined: on overflow, result clamps to the most positive value 0x7FFFFFFF when s > 0, or the most negative value 0x80000000 when s < 0.
- MULT_SATURATE_EN undefined: on overflow, result = s[WIDTH-1:0], i.e. two's-complement wrap.
- The overflow output is present and asserts identically in both builds.

## Structure
- Shared package mult_pkg holds:
  - default WIDTH and FRAC_BITS;
  - functions for the most-positive and most-negative constants as a function of width;
  - the pipeline latency constant, MULT_LATENCY = 2.
- One sub-module is natural: sat_clamp. It takes the 2*WIDTH rescaled value and returns the WIDTH-bit result plus the overflow flag. The MULT_SATURATE_EN guard lives there.

## Test plan
All scenarios use WIDTH = 32 and FRAC_BITS = 0 unless stated otherwise.
- Small integers: x=4, y=2 -> result 0x00000008, overflow 0, out_valid exactly 2 cycles after in_valid.
- Mid-range square: x=0x00000435, y=0x00000435 -> result 0x0011B2F9, overflow 0.
- Negative operand: x=0xFFFFFF18 (-232), y=0x00000435 -> result 0xFFFC2FF8. Also x=0xFFFFFFFE, y=2 -> result 0xFFFFFFFC. Overflow 0 in both.
- Overflow: x=0x7FF00435, y=0x80000435 -> overflow 1. Result 0x80000000 with MULT_SATURATE_EN, 0xBCC1B2F9 without.
- Fixed-point, FRAC_BITS=16:
  - x=0x00018000 (1.5), y=0x00020000 (2.0) -> result 0x00030000.
  - x=0xFFFFFFFF, y=0x00000001 -> result 0xFFFFFFFF (truncation toward minus infinity).
- Streaming with reset: five back-to-back pairs, then rst pulsed for 1 cycle while two are in flight -> those two never emerge, out_valid stays 0, and the outputs read 0 after reset.
